// File: rtl/hazard_track_unit_pkg.sv
// Shared types for the hazard tracker: RV32I opcodes, tracker entry layout
// and the decode helper that classifies register usage of an ID instruction.
package hazard_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } track_entry_t;

    localparam int unsigned ENTRY_W = $bits(track_entry_t);

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } decode_t;

    function automatic decode_t decode_instr(input logic [6:0] opcode, input logic [4:0] rd);
        decode_t d;
        d.uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        d.uses_rs2  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
        d.writes_rd = !(opcode == OPC_STORE || opcode == OPC_BRANCH) && (rd != 5'd0);
        d.is_load   = (opcode == OPC_LOAD);
        return d;
    endfunction

endpackage

// File: rtl/hazard_track_unit_pipe.sv
// DEPTH-entry producer shift register: entry 0 is EX, entry DEPTH-1 is WB.
// Advances every cycle; synchronous reset clears every entry.
module hazard_track_pipe
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ENTRY_W-1:0]       entry_i,
    output logic [DEPTH*ENTRY_W-1:0] stages_o
);

    track_entry_t stage_q [DEPTH];
    track_entry_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = entry_i;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        stages_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stages_o[k*ENTRY_W +: ENTRY_W] = stage_q[k];
        end
    end

endmodule

// File: rtl/hazard_track_unit.sv
// Decode-stage RAW hazard unit: stall, forwarding selects and stall counter
// from an EX..WB producer scoreboard. Define HAZARD_FWD_EN to enable forwarding.
module hazard_track_unit
    import hazard_pkg::*;
#(
    parameter  int unsigned MEM_STAGES = 1,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned DEPTH      = MEM_STAGES + 2,
    localparam int unsigned FW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic             flush,
    output logic             stall,
    output logic [FW-1:0]    fwd_a_sel,
    output logic [FW-1:0]    fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             busy
);

    decode_t                  dec;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    track_entry_t             new_entry;
    track_entry_t             stage [DEPTH];
    logic [DEPTH*ENTRY_W-1:0] stages_flat;
    logic                     a_hit;
    logic                     b_hit;
    logic                     a_blk;
    logic                     b_blk;
    logic                     issue;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic [CNT_W-1:0]         stall_cnt_d;
`ifdef HAZARD_FWD_EN
    logic [FW-1:0]            a_idx;
    logic [FW-1:0]            b_idx;
`else
    logic                     unused_load_bits;
`endif

    assign rs1 = id_ir[19:15];
    assign rs2 = id_ir[24:20];

    always_comb begin
        dec = '0;
        if (id_valid && id_ir != '0) begin
            dec = decode_instr(id_ir[6:0], id_ir[11:7]);
        end
    end

    hazard_track_pipe #(
        .DEPTH(DEPTH)
    ) u_pipe (
        .clk_i   (clk),
        .reset_i (reset),
        .entry_i (new_entry),
        .stages_o(stages_flat)
    );

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage[k] = stages_flat[k*ENTRY_W +: ENTRY_W];
        end
    end

    // Scan EX first so the youngest producer of each source wins.
    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_blk = 1'b0;
        b_blk = 1'b0;
`ifdef HAZARD_FWD_EN
        a_idx = '0;
        b_idx = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!a_hit && dec.uses_rs1 && rs1 != 5'd0 && stage[k].valid && stage[k].rd == rs1) begin
                a_hit = 1'b1;
`ifdef HAZARD_FWD_EN
                a_idx = FW'(k + 1);
                a_blk = stage[k].is_load && (k < MEM_STAGES);
`else
                a_blk = 1'b1;
`endif
            end
            if (!b_hit && dec.uses_rs2 && rs2 != 5'd0 && stage[k].valid && stage[k].rd == rs2) begin
                b_hit = 1'b1;
`ifdef HAZARD_FWD_EN
                b_idx = FW'(k + 1);
                b_blk = stage[k].is_load && (k < MEM_STAGES);
`else
                b_blk = 1'b1;
`endif
            end
        end
    end

    assign stall = (a_blk | b_blk) & id_valid & ~flush;
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        new_entry = '0;
        if (issue && dec.writes_rd) begin
            new_entry.valid   = 1'b1;
            new_entry.rd      = id_ir[11:7];
            new_entry.is_load = dec.is_load;
        end
    end

`ifdef HAZARD_FWD_EN
    assign fwd_a_sel = a_idx;
    assign fwd_b_sel = b_idx;
`else
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;

    // Load tagging only matters when forwarding can pick a stage.
    always_comb begin
        unused_load_bits = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            unused_load_bits = unused_load_bits | stage[k].is_load;
        end
    end
`endif

    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            busy = busy | stage[k].valid;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
